instruction_queue: RTL

//  Circular FIFO between fetch and decode. Buffers fetched {pc, inst} pairs and presents the head entry

---
 rtl/instruction_queue.sv | 69 ++++++
 1 files changed

// File: rtl/instruction_queue.sv
// Show-ahead circular FIFO of {pc, inst} between fetch and decode; head visible combinationally,
// new entries visible one cycle after the enqueue edge; enq_ready = !full from registered count only.
module instruction_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [WIDTH-1:0]         enq_inst,
  input  logic [WIDTH-1:0]         enq_pc,
  output logic                     enq_ready,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [WIDTH-1:0]         deq_inst,
  output logic [WIDTH-1:0]         deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [AW:0]          cnt;
  logic [2*WIDTH-1:0]   mem [DEPTH];
  logic                 enq_fire;
  logic                 deq_fire;
  logic [2*WIDTH-1:0]   head_entry;

  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign enq_ready = ~full;
  assign deq_valid = ~empty;

  // Accepts are judged against registered occupancy; a draining full queue still refuses.
  assign enq_fire = enq_valid & ~full;
  assign deq_fire = deq_ready & ~empty;

  assign head_entry = mem[head];
  assign deq_pc     = empty ? '0 : head_entry[2*WIDTH-1:WIDTH];
  assign deq_inst   = empty ? '0 : head_entry[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately unreset; writes are suppressed while rst or flush is held.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_fire) mem[tail] <= {enq_pc, enq_inst};
  end

endmodule
